pcie_irq_gen: RTL and testbench

// - User-side interrupt source for the XDMA user-IRQ path. Collects up to NUM_SRC event

---
 rtl/pcie_irq_pkg.sv | 17 +
 rtl/pcie_sync_edge.sv | 25 ++
 rtl/pcie_irq_gen.sv | 119 +++++++++++
 tb/tb_pcie_irq_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_irq_pkg.sv
// Shared types and defaults for the user-IRQ request generator.
package pcie_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_ASSERT   = 2'd1,
    IRQ_WAIT_ACK = 2'd2,
    IRQ_HOLDOFF  = 2'd3
  } irq_state_e;

  localparam int RETRY_W         = 8;
  localparam int DEF_NUM_SRC     = 4;
  localparam int DEF_PULSE_W     = 4;
  localparam int DEF_ACK_TIMEOUT = 1024;
  localparam int DEF_HOLDOFF     = 16;

endpackage

// File: rtl/pcie_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; sync reset flushes all stages.
module pcie_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pcie_irq_gen.sv
// User-side interrupt source: pending/mask/in-service tracking and a pulsed request
// with ack wait, timeout retry and post-ack hold-off.
module pcie_irq_gen
  import pcie_irq_pkg::*;
#(
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int PULSE_W     = DEF_PULSE_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int HOLDOFF     = DEF_HOLDOFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_evt_i,
  input  logic [NUM_SRC-1:0] irq_mask_i,
  input  logic [NUM_SRC-1:0] pend_clr_i,
  input  logic               irq_ack_i,
  output logic               user_irq_req_o,
  output logic [NUM_SRC-1:0] irq_pending_o,
  output logic [NUM_SRC-1:0] irq_cause_o,
  output logic               irq_busy_o,
  output logic [RETRY_W-1:0] irq_retry_cnt_o
);

  localparam int PW_W = $clog2(PULSE_W + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT);
  localparam int HO_W = $clog2(HOLDOFF + 1);

  irq_state_e         state, state_nx;
  logic [NUM_SRC-1:0] pending, in_svc, cause, avail;
  logic [PW_W-1:0]    pulse_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [HO_W-1:0]    ho_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               req, ack_pe, ack_seen, trig, snap, timeout, entering;

  pcie_sync_edge u_ack_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (irq_ack_i),
    .rise (ack_pe)
  );

  assign avail    = pending & ~irq_mask_i & ~in_svc;
  assign trig     = |avail;
  assign entering = (state_nx != state);

  always_comb begin
    state_nx = state;
    snap     = 1'b0;
    timeout  = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (trig) begin
          snap     = 1'b1;
          state_nx = IRQ_ASSERT;
        end
      end
      IRQ_ASSERT: begin
        if (pulse_cnt == PW_W'(PULSE_W - 1)) state_nx = IRQ_WAIT_ACK;
      end
      IRQ_WAIT_ACK: begin
        if (ack_pe || ack_seen) begin
          state_nx = IRQ_HOLDOFF;
        end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          timeout  = 1'b1;
          state_nx = IRQ_ASSERT;
        end
      end
      IRQ_HOLDOFF: begin
        if (ho_cnt == HO_W'(HOLDOFF - 1)) state_nx = IRQ_IDLE;
      end
      default: state_nx = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IRQ_IDLE;
      req       <= 1'b0;
      pending   <= '0;
      in_svc    <= '0;
      cause     <= '0;
      ack_seen  <= 1'b0;
      pulse_cnt <= '0;
      to_cnt    <= '0;
      ho_cnt    <= '0;
      retry_cnt <= '0;
    end else begin
      state   <= state_nx;
      req     <= (state_nx == IRQ_ASSERT);
      pending <= (pending & ~pend_clr_i) | src_evt_i;
      in_svc  <= (in_svc & ~pend_clr_i) | (snap ? avail : '0);
      if (snap) cause <= avail;

      // An ack that lands while the pulse is still high is remembered for WAIT_ACK.
      if (entering && state_nx == IRQ_ASSERT) ack_seen <= 1'b0;
      else if (state == IRQ_ASSERT && ack_pe) ack_seen <= 1'b1;

      if (entering) begin
        pulse_cnt <= '0;
        to_cnt    <= '0;
        ho_cnt    <= '0;
      end else begin
        if (state == IRQ_ASSERT)   pulse_cnt <= pulse_cnt + PW_W'(1);
        if (state == IRQ_WAIT_ACK) to_cnt    <= to_cnt + TO_W'(1);
        if (state == IRQ_HOLDOFF)  ho_cnt    <= ho_cnt + HO_W'(1);
      end

      if (timeout && retry_cnt != '1) retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end

  assign user_irq_req_o  = req;
  assign irq_pending_o   = pending;
  assign irq_cause_o     = cause;
  assign irq_busy_o      = (state != IRQ_IDLE);
  assign irq_retry_cnt_o = retry_cnt;

endmodule

// File: tb/tb_pcie_irq_gen.sv
// Directed bench for pcie_irq_gen: request causes are queued when stimulus is driven
// and checked as each request pulse appears.
module tb_pcie_irq_gen;

  localparam int PULSE_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src_evt = '0;
  logic [3:0] mask = '0;
  logic [3:0] pclr = '0;
  logic       ack = 1'b0;
  logic       req;
  logic [3:0] pending;
  logic [3:0] cause;
  logic       busy;
  logic [7:0] retry;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  logic       prev_req = 1'b0;
  int         width = 0;
  bit         aborted = 1'b0;

  always #5 clk = ~clk;

  pcie_irq_gen #(
    .NUM_SRC(4),
    .PULSE_W(PULSE_W),
    .ACK_TIMEOUT(64),
    .HOLDOFF(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_evt_i       (src_evt),
    .irq_mask_i      (mask),
    .pend_clr_i      (pclr),
    .irq_ack_i       (ack),
    .user_irq_req_o  (req),
    .irq_pending_o   (pending),
    .irq_cause_o     (cause),
    .irq_busy_o      (busy),
    .irq_retry_cnt_o (retry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every request rise pops one expected cause; every clean fall checks width.
  task automatic monitor();
    logic [3:0] e;
    if (rst) aborted = 1'b1;
    if (req && !prev_req) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected_req: observed cause %0h expected no request", cause);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_cause", cause, e);
      end
      width   = 1;
      aborted = 1'b0;
    end else if (req) begin
      width++;
    end else if (prev_req && !aborted) begin
      chk("sb_pulse_width", width, PULSE_W);
    end
    prev_req = req;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic pulse_evt(input logic [3:0] v);
    src_evt = v;
    step();
    src_evt = '0;
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (req !== lvl && n < budget) begin
      step();
      n++;
    end
    chk(tag, req, lvl);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic serve(input string tag);
    wait_req(1'b0, 10, {tag, "_req_fall"});
    ack = 1'b1;
    step();
    step();
    ack = 1'b0;
    wait_idle(40, {tag, "_idle"});
  endtask

  initial begin
    int n;

    // reset values
    repeat (3) step();
    chk("rst_req", req, 1'b0);
    chk("rst_pending", pending, 4'h0);
    chk("rst_cause", cause, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_retry", retry, 8'h0);
    rst = 1'b0;
    step();

    // single event, 2-cycle latency, exact hold-off length
    exp_q.push_back(4'b0010);
    pulse_evt(4'b0010);
    chk("t1_pending", pending, 4'b0010);
    chk("t1_req_latency1", req, 1'b0);
    step();
    chk("t1_req_latency2", req, 1'b1);
    chk("t1_busy", busy, 1'b1);
    wait_req(1'b0, 10, "t1_req_fall");
    ack = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 40);
    ack = 1'b0;
    chk("t1_ack_to_idle_cycles", n, 19);
    repeat (5) step();
    chk("t1_no_rerequest", busy, 1'b0);
    chk("t1_pending_kept", pending, 4'b0010);
    pclr = 4'b0010;
    step();
    pclr = '0;
    chk("t1_pending_cleared", pending, 4'b0000);

    // masked source held pending, requested once unmasked
    mask = 4'b0001;
    pulse_evt(4'b0001);
    repeat (3) step();
    chk("t2_masked_pending", pending, 4'b0001);
    chk("t2_masked_idle", busy, 1'b0);
    exp_q.push_back(4'b0001);
    mask = '0;
    step();
    chk("t2_unmask_req", req, 1'b1);
    serve("t2");
    pclr = 4'b0001;
    step();
    pclr = '0;

    // event and clear on the same bit in the same cycle: set wins
    mask = 4'b1000;
    src_evt = 4'b1000;
    pclr = 4'b1000;
    step();
    src_evt = '0;
    pclr = '0;
    chk("t3_set_wins_empty", pending, 4'b1000);
    src_evt = 4'b1000;
    pclr = 4'b1000;
    step();
    src_evt = '0;
    pclr = '0;
    chk("t3_set_wins_full", pending, 4'b1000);
    pclr = 4'b1000;
    step();
    pclr = '0;
    chk("t3_clear", pending, 4'b0000);
    chk("t3_masked_idle", busy, 1'b0);
    mask = '0;

    // event during WAIT_ACK queued behind hold-off; mask change keeps current cause
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    pulse_evt(4'b0001);
    wait_req(1'b1, 4, "t4_req1");
    wait_req(1'b0, 10, "t4_req1_fall");
    mask = 4'b0001;
    pulse_evt(4'b0100);
    chk("t4_pending_both", pending, 4'b0101);
    chk("t4_cause_held", cause, 4'b0001);
    chk("t4_busy", busy, 1'b1);
    mask = '0;
    serve("t4_first");
    wait_req(1'b1, 4, "t4_req2");
    serve("t4_second");
    chk("t4_cause2", cause, 4'b0100);
    pclr = 4'b0101;
    step();
    pclr = '0;

    // ack timeout: retry after 64 WAIT_ACK cycles, then saturation
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    pulse_evt(4'b0010);
    wait_req(1'b1, 4, "t5_req");
    wait_req(1'b0, 10, "t5_req_fall");
    n = 0;
    while (!req && n < 100) begin
      step();
      n++;
    end
    chk("t5_timeout_cycles", n, 64);
    chk("t5_retry1", retry, 8'd1);
    chk("t5_cause_kept", cause, 4'b0010);
    for (int i = 0; i < 299; i++) begin
      exp_q.push_back(4'b0010);
      wait_req(1'b0, 10, "t5_loop_fall");
      wait_req(1'b1, 80, "t5_loop_rise");
    end
    chk("t5_retry_sat", retry, 8'd255);
    serve("t5");
    chk("t5_retry_hold", retry, 8'd255);
    pclr = 4'b0010;
    step();
    pclr = '0;

    // reset in the middle of a request, with an ack pulse inside reset
    exp_q.push_back(4'b0100);
    pulse_evt(4'b0100);
    step();
    chk("t6_req_before_rst", req, 1'b1);
    rst = 1'b1;
    ack = 1'b1;
    step();
    chk("t6_rst_req", req, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_pending", pending, 4'h0);
    chk("t6_rst_cause", cause, 4'h0);
    chk("t6_rst_retry", retry, 8'h0);
    ack = 1'b0;
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("t6_post_rst_idle", busy, 1'b0);
    chk("t6_post_rst_req", req, 1'b0);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
